sl_receiver: RTL

// - SL serial-link receiver; the counterpart of the SL transmitter. Decodes two-wire SL frames

---
 rtl/sl_receiver_if.sv | 25 ++
 rtl/sl_receiver.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sl_receiver_if.sv
`timescale 1ns/1ps
// sl_receiver_if: bundles the SL line inputs and the CPU register port of the
// SL receiver. Optional macro SL_RX_IRQ_EN adds the irq line.
//
// Register port semantics: there is no valid/ready pair. A write is taken on
// every rising clk where wr_en=1, into the register chosen by addr. d_out
// always shows the register chosen by addr, with no wait states. sl0/sl1 are
// free-running level inputs, asynchronous to clk.
interface sl_receiver_if;
  logic        sl0;
  logic        sl1;
  logic        addr;
  logic        wr_en;
  logic [31:0] d_in;
  logic [31:0] d_out;
`ifdef SL_RX_IRQ_EN
  logic        irq;

  modport master (output sl0, sl1, addr, wr_en, d_in, input d_out, irq);
  modport slave  (input sl0, sl1, addr, wr_en, d_in, output d_out, irq);
`else
  modport master (output sl0, sl1, addr, wr_en, d_in, input d_out);
  modport slave  (input sl0, sl1, addr, wr_en, d_in, output d_out);
`endif
endinterface

// File: rtl/sl_receiver.sv
`timescale 1ns/1ps
// sl_receiver: decodes two-wire SL frames (MSB-first data, odd parity bit,
// stop symbol) into a 32-bit word, checks parity/length/timeout, and exposes
// DATA and CTRL/STATUS through a polled register port.
// Optional macro SL_RX_IRQ_EN: adds registered irq output and CTRL[9] irq_mask.
module sl_receiver #(
  parameter int SYNC_STAGES  = 2,
  parameter int TIMEOUT_BASE = 64
) (
  input  logic         clk,
  input  logic         rst,
  sl_receiver_if.slave bus,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BIT  = 2'd1,
    S_GAP  = 2'd2,
    S_STOP = 2'd3
  } state_t;

  // Fill counter width: counts synchronizer stages after reset.
  localparam int FW   = $clog2(SYNC_STAGES + 1);
  // Timeout counter width: large enough for TIMEOUT_BASE << 5.
  localparam int TO_W = $clog2((TIMEOUT_BASE * 32) + 1);

  // Synchronizer and line tracking
  logic [SYNC_STAGES-1:0] sync0_q, sync0_d;
  logic [SYNC_STAGES-1:0] sync1_q, sync1_d;
  logic [FW-1:0]          fill_q, fill_d;
  logic                   armed_q, armed_d;
  logic [1:0]             line_prev_q, line_prev_d;
  logic                   s0, s1;
  logic                   sym_idle, sym_zero, sym_one, sym_stop;
  logic                   line_change, fill_done;

  // Frame FSM and datapath
  state_t                 state_q, state_d;
  logic [32:0]            sr_q, sr_d;
  logic [5:0]             cnt_q, cnt_d;
  logic [5:0]             len_lat_q, len_lat_d;
  logic [2:0]             fm_lat_q, fm_lat_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic [TO_W-1:0]        to_limit;
  logic                   timeout, done, abort;

  // Completion decode
  logic [6:0]             eff_len;
  logic                   len_ok, accept, set_len_err, set_ovr;

  // Register file
  logic                   wr_ctrl;
  logic [5:0]             len_q, len_d;
  logic [2:0]             fm_q, fm_d;
  logic [31:0]            data_q, data_d;
  logic                   ready_q, ready_d;
  logic                   par_err_q, par_err_d;
  logic                   len_err_q, len_err_d;
  logic                   ovr_q, ovr_d;
  logic [31:0]            ctrl_rd;
  logic                   busy;
`ifdef SL_RX_IRQ_EN
  logic                   irq_mask_q, irq_mask_d;
  logic                   irq_q, irq_d;
  logic                   unused_d_in;
  assign unused_d_in = ^{bus.d_in[31:21], bus.d_in[16:10]};
`else
  logic                   unused_d_in;
  assign unused_d_in = ^{bus.d_in[31:21], bus.d_in[16:9]};
`endif

  // Synchronized line levels; symbol pair is {sl0, sl1}.
  assign s0          = sync0_q[SYNC_STAGES-1];
  assign s1          = sync1_q[SYNC_STAGES-1];
  assign sym_idle    = s0 & s1;
  assign sym_zero    = ~s0 & s1;
  assign sym_one     = s0 & ~s1;
  assign sym_stop    = ~s0 & ~s1;
  assign line_change = ({s0, s1} != line_prev_q);
  assign fill_done   = (fill_q == FW'(SYNC_STAGES));

  // Abort once the line has been stable for the latched timeout length.
  assign to_limit    = TO_W'(TIMEOUT_BASE) << fm_lat_q;
  assign timeout     = ~line_change && ((to_cnt_q + TO_W'(1)) == to_limit);

  assign busy        = (state_q != S_IDLE);
  assign dbg_state   = state_q;
  assign wr_ctrl     = bus.wr_en & bus.addr;

  // Synchronizer shift, line history, and re-arm after a genuine idle level.
  // Reset leaves the synchronizer at 1s, so a frame may only start once the
  // real sampled lines have shown 11 after the pipeline has filled.
  always_comb begin
    sync0_d     = {sync0_q[SYNC_STAGES-2:0], bus.sl0};
    sync1_d     = {sync1_q[SYNC_STAGES-2:0], bus.sl1};
    fill_d      = fill_done ? fill_q : fill_q + FW'(1);
    line_prev_d = {s0, s1};
    armed_d     = fill_done &
                  (sym_idle | (armed_q & (state_q == S_IDLE) & ~sym_stop));
  end

  // Synchronizer and line-tracking registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0_q     <= '1;
      sync1_q     <= '1;
      fill_q      <= '0;
      armed_q     <= 1'b0;
      line_prev_q <= 2'b11;
    end else begin
      sync0_q     <= sync0_d;
      sync1_q     <= sync1_d;
      fill_q      <= fill_d;
      armed_q     <= armed_d;
      line_prev_q <= line_prev_d;
    end
  end

  // Frame FSM next state, shift register, bit counter and timeout counter.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    len_lat_d = len_lat_q;
    fm_lat_d  = fm_lat_q;
    to_cnt_d  = '0;
    done      = 1'b0;
    abort     = 1'b0;
    if (state_q != S_IDLE) begin
      to_cnt_d = line_change ? '0 : to_cnt_q + TO_W'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (armed_q && (sym_zero || sym_one)) begin
          len_lat_d = len_q;
          fm_lat_d  = (fm_q > 3'd5) ? 3'd5 : fm_q;
          sr_d      = {32'd0, sym_one};
          cnt_d     = 6'd1;
          state_d   = S_BIT;
        end
      end
      S_BIT: begin
        if (sym_idle) begin
          state_d = S_GAP;
        end else if (sym_stop) begin
          state_d = S_STOP;
        end
      end
      S_GAP: begin
        if (sym_zero || sym_one) begin
          sr_d    = {sr_q[31:0], sym_one};
          cnt_d   = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
          state_d = S_BIT;
        end else if (sym_stop) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (sym_idle) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (timeout && (state_q != S_IDLE) && !done) begin
      abort    = 1'b1;
      state_d  = S_IDLE;
      to_cnt_d = '0;
    end
  end

  // Frame FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      len_lat_q <= 6'd8;
      fm_lat_q  <= '0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      len_lat_q <= len_lat_d;
      fm_lat_q  <= fm_lat_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  // LEN 0 and LEN above 32 both mean a 32-bit word; frame carries LEN+1 bits.
  assign eff_len     = ((len_lat_q == 6'd0) || (len_lat_q > 6'd32)) ? 7'd32
                                                                     : {1'b0, len_lat_q};
  assign len_ok      = ({1'b0, cnt_q} == (eff_len + 7'd1));
  assign accept      = done & len_ok & ~ready_q;
  assign set_ovr     = done & len_ok & ready_q;
  assign set_len_err = abort | (done & ~len_ok);

  // Register updates: w1c clears first, then flag sets so a set wins.
  always_comb begin
    len_d     = len_q;
    fm_d      = fm_q;
    data_d    = data_q;
    ready_d   = ready_q   & ~(wr_ctrl & bus.d_in[17]);
    par_err_d = par_err_q & ~(wr_ctrl & bus.d_in[18]);
    len_err_d = len_err_q & ~(wr_ctrl & bus.d_in[19]);
    ovr_d     = ovr_q     & ~(wr_ctrl & bus.d_in[20]);
`ifdef SL_RX_IRQ_EN
    irq_mask_d = irq_mask_q;
`endif
    if (wr_ctrl) begin
      len_d = bus.d_in[5:0];
      fm_d  = bus.d_in[8:6];
`ifdef SL_RX_IRQ_EN
      irq_mask_d = bus.d_in[9];
`endif
    end
    if (accept) begin
      // Shift register was cleared at frame start, so bits above LEN are 0.
      data_d  = sr_q[32:1];
      ready_d = 1'b1;
      if (~^sr_q) begin
        par_err_d = 1'b1;
      end
    end
    if (set_len_err) begin
      len_err_d = 1'b1;
    end
    if (set_ovr) begin
      ovr_d = 1'b1;
    end
`ifdef SL_RX_IRQ_EN
    irq_d = ~irq_mask_d & (ready_d | par_err_d | len_err_d | ovr_d);
`endif
  end

  // Register file and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= 6'd8;
      fm_q      <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      par_err_q <= 1'b0;
      len_err_q <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef SL_RX_IRQ_EN
      irq_mask_q <= 1'b0;
      irq_q      <= 1'b0;
`endif
    end else begin
      len_q     <= len_d;
      fm_q      <= fm_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      par_err_q <= par_err_d;
      len_err_q <= len_err_d;
      ovr_q     <= ovr_d;
`ifdef SL_RX_IRQ_EN
      irq_mask_q <= irq_mask_d;
      irq_q      <= irq_d;
`endif
    end
  end

`ifdef SL_RX_IRQ_EN
  assign bus.irq = irq_q;
`endif

  // Combinational read mux for the selected register.
  always_comb begin
    ctrl_rd      = 32'd0;
    ctrl_rd[5:0] = len_q;
    ctrl_rd[8:6] = fm_q;
`ifdef SL_RX_IRQ_EN
    ctrl_rd[9]   = irq_mask_q;
`endif
    ctrl_rd[16]  = busy;
    ctrl_rd[17]  = ready_q;
    ctrl_rd[18]  = par_err_q;
    ctrl_rd[19]  = len_err_q;
    ctrl_rd[20]  = ovr_q;
    bus.d_out    = bus.addr ? ctrl_rd : data_q;
  end

endmodule
